data_cache: RTL
===============

Name: data_cache

Overview:
- Direct-mapped, write-through, read-allocate data cache placed between the pipeline's Memory stage and the backing data memory.
- Serves loads combinationally on a hit.
- On a miss or a write, it stalls the pipeline and runs the backing-memory handshake.
- Byte, halfword and word load/store sizing and load sign-extension are done here, so the backing memory always sees aligned word transactions with byte strobes.

Parameters:
- WIDTH, 32, data and address width.
- SETS, 64, number of lines; power of two; index = addr[3+log2(SETS):4].
- LINE_WORDS, 4, words per line; fixed at 4; word-in-line = addr[3:2].

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_rd_en  in  1  load request (from MemReadM).
- cpu_wr_en  in  1  store request (from MemWriteM).
- cpu_addr  in  WIDTH  byte address (ALUResultM).
- cpu_wdata  in  WIDTH  store data, right-aligned (WriteDataM).
- cpu_mode  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- cpu_rdata  out  WIDTH  extended load result.
- cpu_stall  out  1  freeze F/D/E/M; combinational.
- mem_req  out  1  backing-memory request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  WIDTH  word-aligned address (bits [1:0] = 0).
- mem_wdata  out  WIDTH  lane-aligned store data.
- mem_wstrb  out  4  byte enables for writes.
- mem_ack  in  1  one-cycle completion pulse.
- mem_rdata  in  WIDTH  read word, valid with mem_ack.

Behaviour:
- Reset:
  - Every valid bit cleared; state = IDLE; beat counter = 0.
  - mem_req = 0, mem_we = 0, mem_wstrb = 0, cpu_stall = 0, cpu_rdata = 0.
  - Reset asserted mid-REFILL or mid-WRITE aborts the transaction. Any mem_ack arriving after reset is ignored.
- Hit: valid[index] and tag[index] == addr[WIDTH-1:4+log2(SETS)].
- FSM states: IDLE, REFILL, WRITE, FILL_DONE.
- IDLE:
  - Read hit: cpu_rdata valid in the same cycle (zero latency); cpu_stall = 0.
  - Read miss: cpu_stall = 1; next state REFILL; beat = 0.
  - Write (hit or miss): cpu_stall = 1; next state WRITE.
  - If both cpu_rd_en and cpu_wr_en are high, the write takes priority.
- REFILL:
  - mem_req = 1, mem_we = 0, mem_addr = {tag, index, beat, 2'b00}.
  - On mem_ack: the data word at beat is written from mem_rdata, and beat increments.
  - When the ack for beat 3 arrives: set valid and tag, go to FILL_DONE.
  - Beats are strictly sequential, 0 to 3.
- FILL_DONE:
  - One-cycle bubble; cpu_stall = 1; next state IDLE.
  - In IDLE the access re-looks-up and hits. Minimum miss penalty = 4 acks + 2 cycles.
- WRITE:
  - mem_req = 1, mem_we = 1, mem_addr = {addr[WIDTH-1:2], 2'b00}, mem_wstrb and mem_wdata from sizing.
  - All request outputs are held stable until mem_ack.
  - In the mem_ack cycle: cpu_stall = 0 and state returns to IDLE.
  - Also in that cycle, if the line hits, the strobed bytes of the cached word are updated (write-through).
  - A write miss does not allocate (no-write-allocate).
- Store sizing:
  - B: strobe = 1 << addr[1:0], data replicated into all four byte lanes.
  - H: strobe = 0011 or 1100 selected by addr[1], data replicated into both halves.
  - W: strobe = 1111.
- Load sizing:
  - B/BU select the byte by addr[1:0] and H/HU select the half by addr[1].
  - B and H are sign-extended; BU and HU are zero-extended.
  - Halfword at addr[0] = 1 and word at addr[1:0] != 0 are unsupported. Output is undefined but the FSM must not hang.
- mem_req is never asserted in IDLE or FILL_DONE.
- mem_ack received in IDLE is ignored.
- cpu_rd_en and cpu_wr_en must be held stable while cpu_stall = 1; this is guaranteed by the pipeline freeze.

Decomposition:
- Package riscv_mem_pkg: funct3 load/store mode constants, the dcache_state_t enum {IDLE, REFILL, WRITE, FILL_DONE}, and the tag/index/offset width localparams derived from SETS.
- Sub-module lsu_align (combinational): store lane/strobe generation and load byte-select plus extension, reusable by the uncached path.

Test Plan:
- Reset, then LW 0x100 with backing memory words 0x100..0x10C = 11, 22, 33, 44 and a 2-cycle ack delay:
  - 4 read beats at 0x100, 0x104, 0x108, 0x10C.
  - cpu_stall stays high until the post-FILL_DONE lookup, then cpu_rdata = 11.
- Follow-up LW 0x108 -> no mem_req, cpu_stall = 0, cpu_rdata = 33 in the same cycle.
- Word 0x100 = 0x8000_80F0 cached:
  - LB 0x100 -> 0xFFFF_FFF0.
  - LBU 0x100 -> 0x0000_00F0.
  - LH 0x102 -> 0xFFFF_8000.
  - LHU 0x102 -> 0x0000_8000.
- SB 0x101 with data 0xAB on a hit line:
  - mem_we = 1, mem_wstrb = 0010, mem_wdata = 0xABAB_ABAB.
  - After ack, LW 0x100 hits with byte1 = 0xAB.
- SW to uncached 0x400, then LW 0x400 -> the write does not allocate; the load misses and refills.
- rst asserted after beat 1 of a refill:
  - Next cycle mem_req = 0 and cpu_stall = 0.
  - LW 0x100 then misses again (valid cleared).

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared load/store encodings, data-cache FSM states and default geometry
// for the memory-stage blocks.
package riscv_mem_pkg;

    localparam int unsigned XLEN          = 32;
    localparam int unsigned DC_SETS       = 64;
    localparam int unsigned DC_LINE_WORDS = 4;
    localparam int unsigned DC_OFF_W      = 4;
    localparam int unsigned DC_IDX_W      = $clog2(DC_SETS);
    localparam int unsigned DC_TAG_W      = XLEN - DC_OFF_W - DC_IDX_W;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REFILL    = 2'd1,
        WRITE     = 2'd2,
        FILL_DONE = 2'd3
    } dcache_state_t;

endpackage

// File: rtl/lsu_align.sv
// Load/store lane alignment: store byte-lane replication and strobes,
// load byte/half selection with sign or zero extension.
module lsu_align
    import riscv_mem_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2:0]       i_mode,
    input  logic [1:0]       i_addr_lo,
    input  logic [WIDTH-1:0] i_store_data,
    input  logic [WIDTH-1:0] i_load_word,
    output logic [WIDTH-1:0] o_store_data,
    output logic [3:0]       o_store_strb,
    output logic [WIDTH-1:0] o_load_data
);

    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;

    // Store side: narrow stores are replicated so any lane can be strobed
    always_comb begin
        o_store_data = i_store_data;
        o_store_strb = 4'b1111;
        case (i_mode[1:0])
            2'b00: begin
                o_store_data = {(WIDTH/8){i_store_data[7:0]}};
                o_store_strb = 4'b0001 << i_addr_lo;
            end
            2'b01: begin
                o_store_data = {(WIDTH/16){i_store_data[15:0]}};
                o_store_strb = i_addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                o_store_data = i_store_data;
                o_store_strb = 4'b1111;
            end
        endcase
    end

    always_comb begin
        w_ld_byte   = i_load_word[8*i_addr_lo +: 8];
        w_ld_half   = i_addr_lo[1] ? i_load_word[31:16] : i_load_word[15:0];
        o_load_data = i_load_word;
        case (i_mode)
            F3_B:    o_load_data = {{(WIDTH-8){w_ld_byte[7]}}, w_ld_byte};
            F3_BU:   o_load_data = {{(WIDTH-8){1'b0}}, w_ld_byte};
            F3_H:    o_load_data = {{(WIDTH-16){w_ld_half[15]}}, w_ld_half};
            F3_HU:   o_load_data = {{(WIDTH-16){1'b0}}, w_ld_half};
            default: o_load_data = i_load_word;
        endcase
    end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, read-allocate data cache between the
// Memory stage and the backing data memory.
module data_cache
    import riscv_mem_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned SETS       = 64,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_rd_en,
    input  logic             cpu_wr_en,
    input  logic [WIDTH-1:0] cpu_addr,
    input  logic [WIDTH-1:0] cpu_wdata,
    input  logic [2:0]       cpu_mode,
    output logic [WIDTH-1:0] cpu_rdata,
    output logic             cpu_stall,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [3:0]       mem_wstrb,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata
);

    localparam int unsigned IDX_W  = $clog2(SETS);
    localparam int unsigned WORD_W = $clog2(LINE_WORDS);
    localparam int unsigned OFF_W  = WORD_W + 2;
    localparam int unsigned TAG_W  = WIDTH - OFF_W - IDX_W;

    dcache_state_t r_state;
    dcache_state_t w_next_state;

    logic [WORD_W-1:0] r_beat;
    logic              r_valid [SETS];
    logic [TAG_W-1:0]  r_tag   [SETS];
    logic [WIDTH-1:0]  r_data  [SETS][LINE_WORDS];

    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic [WORD_W-1:0] w_word;
    logic              w_hit;
    logic [WIDTH-1:0]  w_line_word;
    logic [WIDTH-1:0]  w_st_data;
    logic [3:0]        w_st_strb;
    logic [WIDTH-1:0]  w_ld_data;

    assign w_idx       = cpu_addr[OFF_W +: IDX_W];
    assign w_tag       = cpu_addr[WIDTH-1 -: TAG_W];
    assign w_word      = cpu_addr[3:2];
    assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_line_word = r_data[w_idx][w_word];

    lsu_align #(.WIDTH(WIDTH)) u_align (
        .i_mode       (cpu_mode),
        .i_addr_lo    (cpu_addr[1:0]),
        .i_store_data (cpu_wdata),
        .i_load_word  (w_line_word),
        .o_store_data (w_st_data),
        .o_store_strb (w_st_strb),
        .o_load_data  (w_ld_data)
    );

    always_comb begin
        w_next_state = r_state;
        cpu_stall    = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_wstrb    = 4'b0000;
        case (r_state)
            IDLE: begin
                if (cpu_wr_en) begin
                    cpu_stall    = 1'b1;
                    w_next_state = WRITE;
                end else if (cpu_rd_en && !w_hit) begin
                    cpu_stall    = 1'b1;
                    w_next_state = REFILL;
                end
            end
            REFILL: begin
                cpu_stall = 1'b1;
                mem_req   = 1'b1;
                mem_addr  = {w_tag, w_idx, r_beat, 2'b00};
                if (mem_ack && (r_beat == WORD_W'(LINE_WORDS - 1))) begin
                    w_next_state = FILL_DONE;
                end
            end
            WRITE: begin
                cpu_stall = !mem_ack;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {cpu_addr[WIDTH-1:2], 2'b00};
                mem_wdata = w_st_data;
                mem_wstrb = w_st_strb;
                if (mem_ack) begin
                    w_next_state = IDLE;
                end
            end
            FILL_DONE: begin
                cpu_stall    = 1'b1;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Load data is only presented on a genuine zero-latency hit
    assign cpu_rdata = (r_state == IDLE && cpu_rd_en && !cpu_wr_en && w_hit) ? w_ld_data : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_beat  <= '0;
            for (int i = 0; i < int'(SETS); i++) begin
                r_valid[i] <= 1'b0;
            end
        end else begin
            r_state <= w_next_state;
            if (r_state == IDLE && w_next_state == REFILL) begin
                r_beat <= '0;
            end
            if (r_state == REFILL && mem_ack) begin
                r_beat <= r_beat + WORD_W'(1);
                if (r_beat == WORD_W'(LINE_WORDS - 1)) begin
                    r_valid[w_idx] <= 1'b1;
                    r_tag[w_idx]   <= w_tag;
                end
            end
        end
    end

    // Line storage: refill beats, and write-through of strobed bytes on a hit
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == REFILL && mem_ack) begin
                r_data[w_idx][r_beat] <= mem_rdata;
            end
            if (r_state == WRITE && mem_ack && w_hit) begin
                for (int b = 0; b < 4; b++) begin
                    if (w_st_strb[b]) begin
                        r_data[w_idx][w_word][8*b +: 8] <= w_st_data[8*b +: 8];
                    end
                end
            end
        end
    end

endmodule
